// File: rtl/gamepad_pmod_receiver.sv
// Serial gamepad receiver: synchronises a clock/data/latch PMOD link, shifts in
// controller bits and publishes debounced-free button levels with edge pulses.
module gamepad_pmod_receiver #(
  parameter int unsigned NUM_PADS       = 2,
  parameter int unsigned BITS_PER_PAD   = 12,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pmod_data,
  input  logic                             pmod_clk,
  input  logic                             pmod_latch,
  output logic [NUM_PADS*BITS_PER_PAD-1:0] buttons,
  output logic [NUM_PADS-1:0]              present,
  output logic [NUM_PADS*BITS_PER_PAD-1:0] pressed,
  output logic [NUM_PADS*BITS_PER_PAD-1:0] released,
  output logic                             frame_valid,
  output logic                             frame_error,
  output logic                             stale
);

  localparam int unsigned W    = NUM_PADS * BITS_PER_PAD;
  localparam int unsigned CntW = $clog2(W + 2);
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0] data_sync_q, clk_sync_q, latch_sync_q;
  logic                   clk_prev_q, latch_prev_q;
  logic [W-1:0]           shift_q, raw_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [TmoW-1:0]        tmo_q;

  logic         data_s, clk_s, latch_s;
  logic         clk_rise, latch_rise, count_ok, accept, reject, tmo_fire, update;
  logic [W-1:0] new_raw, new_buttons;
  logic [NUM_PADS-1:0] new_present;

  assign data_s     = data_sync_q[SYNC_STAGES-1];
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign clk_rise   = clk_s & ~clk_prev_q;
  assign latch_rise = latch_s & ~latch_prev_q;

  always_comb begin
    count_ok = 1'b0;
    for (int unsigned k = 1; k <= NUM_PADS; k++) begin
      if (bit_cnt_q == CntW'(k * BITS_PER_PAD)) count_ok = 1'b1;
    end
  end

  // A bit clock coinciding with the latch is ambiguous, so the frame is dropped.
  assign accept   = latch_rise & ~clk_rise & count_ok;
  assign reject   = latch_rise & ~accept;
  assign tmo_fire = (TIMEOUT_CYCLES != 0) && !accept &&
                    (32'(tmo_q) == TIMEOUT_CYCLES - 1);
  assign update   = accept | tmo_fire;

  always_comb begin
    new_raw = raw_q;
    if (accept)        new_raw = shift_q;
    else if (tmo_fire) new_raw = '1;
  end

  // An all-ones slice means the pad's data line floated high: nothing attached.
  always_comb begin
    new_buttons = '0;
    new_present = '0;
    for (int p = 0; p < int'(NUM_PADS); p++) begin
      if (new_raw[p*BITS_PER_PAD +: BITS_PER_PAD] != '1) begin
        new_present[p]                         = 1'b1;
        new_buttons[p*BITS_PER_PAD +: BITS_PER_PAD] = new_raw[p*BITS_PER_PAD +: BITS_PER_PAD];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync_q  <= '0;
      clk_sync_q   <= '0;
      latch_sync_q <= '0;
      clk_prev_q   <= 1'b0;
      latch_prev_q <= 1'b0;
      shift_q      <= '1;
      raw_q        <= '1;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      buttons      <= '0;
      present      <= '0;
      pressed      <= '0;
      released     <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      stale        <= 1'b1;
    end else begin
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], pmod_data};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], pmod_clk};
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pmod_latch};
      clk_prev_q   <= clk_s;
      latch_prev_q <= latch_s;

      if (latch_rise) begin
        shift_q   <= '1;
        bit_cnt_q <= '0;
      end else if (clk_rise) begin
        shift_q <= {shift_q[W-2:0], data_s};
        if (bit_cnt_q != CntW'(W + 1)) bit_cnt_q <= bit_cnt_q + CntW'(1);
      end

      if (TIMEOUT_CYCLES == 0 || accept) tmo_q <= '0;
      else if (32'(tmo_q) != TIMEOUT_CYCLES) tmo_q <= tmo_q + TmoW'(1);

      raw_q <= new_raw;
      if (update) begin
        buttons  <= new_buttons;
        present  <= new_present;
        pressed  <= new_buttons & ~buttons;
        released <= ~new_buttons & buttons;
      end else begin
        pressed  <= '0;
        released <= '0;
      end

      frame_valid <= accept;
      frame_error <= reject;
      if (accept)        stale <= 1'b0;
      else if (tmo_fire) stale <= 1'b1;
    end
  end

endmodule

// File: doc/gamepad_pmod_receiver.md
GAMEPAD_PMOD_RECEIVER -- requirements
Module: gamepad_pmod_receiver

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2: controllers per frame, legal 1..4.
REQ-002 SHALL have parameter BITS_PER_PAD, default 12: bits per controller, legal 4..16.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, legal 2..3.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2000000: clk cycles without an accepted frame before staleness; 0 disables the timeout.
REQ-005 SHALL have ports (W = NUM_PADS*BITS_PER_PAD):
  clk  in  1  system clock.
  rst_n  in  1  reset; asynchronous, active-low.
  pmod_data  in  1  serial data, async to clk.
  pmod_clk  in  1  serial bit clock, async to clk.
  pmod_latch  in  1  frame latch, async to clk.
  buttons  out  W  decoded button levels; pad p at [p*BITS_PER_PAD +: BITS_PER_PAD]; 1 = pressed.
  present  out  NUM_PADS  per-pad connected flag.
  pressed  out  W  one-cycle pulse per button, 0->1 transition.
  released  out  W  one-cycle pulse per button, 1->0 transition.
  frame_valid  out  1  one-cycle pulse, frame accepted.
  frame_error  out  1  one-cycle pulse, frame rejected.
  stale  out  1  level: no accepted frame within TIMEOUT_CYCLES.

Function
REQ-006 SHALL pass pmod_data, pmod_clk and pmod_latch each through a SYNC_STAGES-deep flop chain; all logic SHALL use only the synchronised versions.
REQ-007 SHALL detect rising edges by comparing each synchronised signal with a one-cycle-delayed copy.
REQ-008 On pmod_clk rise (no latch rise that cycle): shift_reg <= {shift_reg[W-2:0], data}; bit_cnt increments, saturating at W+1.
REQ-009 On pmod_latch rise: frame SHALL be accepted iff bit_cnt = k*BITS_PER_PAD for some k in 1..NUM_PADS; else rejected.
REQ-010 Accept: raw_reg <= shift_reg; pads k..NUM_PADS-1 therefore hold all-ones, since shift_reg is preloaded with ones.
REQ-011 Every latch rise, accepted or rejected: shift_reg <= all ones, bit_cnt <= 0.
REQ-012 Reject: raw_reg, buttons and present unchanged; frame_error = 1 for one cycle.
REQ-013 pmod_clk rise and pmod_latch rise in the same cycle: frame rejected, coincident bit discarded.
REQ-014 Pad 0 = the last BITS_PER_PAD bits shifted; within a pad the first-shifted bit is the MSB (12-bit order b,y,select,start,up,down,left,right,a,x,l,r, MSB to LSB).
REQ-015 Pad slice all-ones: present[p] = 0 and buttons slice = 0; otherwise present[p] = 1 and buttons slice = raw slice.
REQ-016 buttons, present, pressed, released, frame_valid SHALL be registered and update on the clk edge after the synchronised latch rise is detected; pin-to-output latency = SYNC_STAGES+1 clk edges.
REQ-017 pressed = new_buttons & ~buttons and released = ~new_buttons & buttons, evaluated on every buttons update; both are 0 on all other cycles.
REQ-018 Timeout counter increments each cycle, clears on accept, saturates at TIMEOUT_CYCLES.
REQ-019 On reaching TIMEOUT_CYCLES: raw_reg <= all ones, so all pads go absent, with released pulses for held buttons; stale = 1.
REQ-020 stale clears on the same edge a frame is accepted.
REQ-021 Accept and timeout in the same cycle: accept wins, stale = 0.
REQ-022 bit_cnt saturated at W+1 SHALL cause rejection at the next latch rise.

Reset
REQ-023 rst_n low SHALL asynchronously set: sync chains and edge-history flops 0; shift_reg and raw_reg all ones; bit_cnt and timeout counter 0; buttons, present, pressed, released, frame_valid, frame_error 0; stale 1.
REQ-024 Reset mid-frame SHALL discard partial bits; the first latch rise after release judges only bits received after release.
REQ-025 No pressed or released pulse SHALL be generated by reset entry or exit.

Verification
REQ-026 NUM_PADS=2, BITS_PER_PAD=12: send 24 bits, pad1 = 0x800, pad0 = 0x00F, then latch -> buttons = 0x80000F, present = 2'b11, frame_valid pulse, pressed = 0x80000F, stale = 0.
REQ-027 Send 12 bits = 0x010, latch -> present = 2'b01, buttons[11:0] = 0x010, buttons[23:12] = 0; next frame 0x000 -> released[4] pulse only.
REQ-028 Send 13 bits, latch -> frame_error pulse, outputs unchanged; a following valid 24-bit frame is accepted normally.
REQ-029 TIMEOUT_CYCLES = 100, hold button a after one accepted frame, stop traffic -> at 100 cycles stale = 1, present = 0, released pulse on a.
REQ-030 Assert rst_n low after 7 shifted bits, release, send a 24-bit frame -> accepted, no frame_error; reset asserted between clk edges clears outputs immediately.
REQ-031 Drive pmod_clk and pmod_latch rising simultaneously after 23 bits -> frame_error, raw data unchanged.
